// File: rtl/pad_1wire_pkg.sv
// Shared types and frame constants for the single-wire pad transceiver.
// Optional even parity is enabled by defining PAD_1WIRE_XCVR_PARITY_EN.
package pad_1wire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TURN,
    RX_START,
    RX_DATA,
    RX_STOP
  } state_t;

  localparam int unsigned DATA_BITS = 8;
`ifdef PAD_1WIRE_XCVR_PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_BITS + 1;
`else
  localparam int unsigned FRAME_BITS = DATA_BITS;
`endif
  localparam int unsigned IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  function automatic logic even_par(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  // Payload bits in wire order (LSB first), parity appended when enabled.
  function automatic logic [FRAME_BITS-1:0] tx_frame(input logic [DATA_BITS-1:0] d);
`ifdef PAD_1WIRE_XCVR_PARITY_EN
    return {even_par(d), d};
`else
    return d;
`endif
  endfunction

endpackage

// File: rtl/pad_sync2.sv
// Two-flop synchronizer for the asynchronous pad input; resets to the
// released-line level so reset never looks like a start bit.
module pad_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make the two flops a true two-stage
  // shift; blocking ones would collapse them into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pad_1wire_xcvr.sv
// Half-duplex single-wire UART-style transceiver driving a tri-state pad.
// Build with PAD_1WIRE_XCVR_PARITY_EN defined to add an even-parity bit.
module pad_1wire_xcvr
  import pad_1wire_pkg::*;
#(
  parameter int unsigned CLKDIV   = 8,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       pad_o,
  output logic       pad_noe,
  input  logic       pad_i,
  output logic       busy
);

  localparam int unsigned CNT_SPAN = (CLKDIV > TURN_CYC) ? CLKDIV : TURN_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_SPAN);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKDIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKDIV / 2 - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [FRAME_BITS-1:0]  tx_sh, tx_sh_nxt;
  logic [FRAME_BITS-1:0]  rx_sh, rx_sh_nxt;
  logic [7:0]             rx_data_nxt;
  logic                   rx_valid_nxt, rx_err_nxt;
  logic                   rx_s, rx_prev, rx_fall;
  logic                   tx_en;
  logic                   bit_end;
  logic                   par_ok;

  pad_sync2 u_sync (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .d     (pad_i),
    .q     (rx_s)
  );

  assign rx_fall = rx_prev & ~rx_s;
  assign bit_end = (cnt == BIT_LAST);
  assign busy    = (state != IDLE);

`ifdef PAD_1WIRE_XCVR_PARITY_EN
  assign par_ok = (rx_sh[FRAME_BITS-1] == even_par(rx_sh[7:0]));
`else
  assign par_ok = 1'b1;
`endif

  // tx_en holds tx_ready low until the first clock after reset release.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      rx_prev  <= 1'b1;
      tx_en    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      tx_sh    <= tx_sh_nxt;
      rx_sh    <= rx_sh_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      rx_err   <= rx_err_nxt;
      rx_prev  <= rx_s;
      tx_en    <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + 1'b1;
    idx_nxt      = idx;
    tx_sh_nxt    = tx_sh;
    rx_sh_nxt    = rx_sh;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    rx_err_nxt   = 1'b0;
    pad_o        = 1'b1;
    pad_noe      = 1'b1;
    tx_ready     = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (rx_fall) begin
          state_nxt = RX_START;
        end else if (tx_en) begin
          tx_ready = 1'b1;
          if (tx_valid) begin
            tx_sh_nxt = tx_frame(tx_data);
            state_nxt = TX_START;
          end
        end
      end

      TX_START: begin
        pad_noe = 1'b0;
        pad_o   = 1'b0;
        if (bit_end) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = TX_DATA;
        end
      end

      TX_DATA: begin
        pad_noe = 1'b0;
        pad_o   = tx_sh[0];
        if (bit_end) begin
          cnt_nxt   = '0;
          tx_sh_nxt = tx_sh >> 1;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = TX_STOP;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end

      TX_STOP: begin
        pad_noe = 1'b0;
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = TURN;
        end
      end

      // Line is released but the synchronizer still carries our own stop
      // bit; pad_i is ignored until it has drained.
      TURN: begin
        if (cnt == TURN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end

      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : RX_DATA;
        end
      end

      // Sampling one full bit after the start-bit midpoint lands mid-bit.
      RX_DATA: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          rx_sh_nxt = {rx_s, rx_sh[FRAME_BITS-1:1]};
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = RX_STOP;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end

      RX_STOP: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_s && par_ok) begin
            rx_data_nxt  = rx_sh[7:0];
            rx_valid_nxt = 1'b1;
          end else begin
            rx_err_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
